// File: rtl/rr_pkt_arb.sv
// rr_pkt_arb: packet-granular round-robin arbiter sharing one valid/ready channel among N requesters.
// Build option RR_PKT_ARB_OUT_REG_EN: 2-entry skid buffer on the output (1-cycle latency, full rate).
//
// state  | meaning
// IDLE   | between packets; round-robin pick starting at ptr, pick frozen while stalled
// LOCKED | mid-packet; only owner is forwarded until its last beat is accepted
module rr_pkt_arb #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic [N-1:0]         i_in_vld,
  input  logic [N-1:0]         i_in_last,
  input  logic [N*W-1:0]       i_in_dat,
  output logic [N-1:0]         o_in_rdy,
  output logic                 o_out_vld,
  output logic                 o_out_last,
  output logic [W-1:0]         o_out_dat,
  output logic [$clog2(N)-1:0] o_out_id,
  input  logic                 i_out_rdy,
  output logic                 o_busy
);
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d, hold_sel_q, hold_sel_d;
  logic [IW-1:0] rr_sel, cand, cur;
  logic [IW:0]   sum;
  logic          hold_q, hold_d, run_q, found;
  logic          arb_vld, arb_last, arb_rdy, fire;
  logic [W-1:0]  arb_dat;
  logic [N-1:0]  in_rdy;

  function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] v);
    return (v == IW'(N - 1)) ? '0 : v + 1'b1;
  endfunction

  // Wrapping search ptr, ptr+1, .. ; one extra bit so non-power-of-2 N wraps correctly.
  always_comb begin
    found  = 1'b0;
    rr_sel = '0;
    sum    = '0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (!found && i_in_vld[cand]) begin
        found  = 1'b1;
        rr_sel = cand;
      end
    end
  end

  always_comb begin
    cur      = (state_q == LOCKED) ? owner_q : (hold_q ? hold_sel_q : rr_sel);
    arb_vld  = run_q & i_in_vld[cur];
    arb_last = i_in_last[cur];
    arb_dat  = i_in_dat[cur*W +: W];
    fire     = arb_vld & arb_rdy;
    in_rdy   = '0;
    in_rdy[cur] = fire;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    hold_d     = 1'b0;
    hold_sel_d = hold_sel_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          if (arb_last) begin
            ptr_d = inc_mod(cur);
          end else begin
            state_d = LOCKED;
            owner_d = cur;
          end
        end else if (arb_vld) begin
          hold_d     = 1'b1;
          hold_sel_d = cur;
        end
      end
      LOCKED: begin
        if (fire && arb_last) begin
          state_d = IDLE;
          ptr_d   = inc_mod(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // run_q keeps the combinational forward path quiet during and just after reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      hold_q     <= 1'b0;
      hold_sel_q <= '0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      hold_q     <= hold_d;
      hold_sel_q <= hold_sel_d;
      run_q      <= 1'b1;
    end
  end

  assign o_in_rdy = in_rdy;
  assign o_busy   = (state_q == LOCKED);

`ifdef RR_PKT_ARB_OUT_REG_EN
  logic [W-1:0]  buf_dat  [2];
  logic          buf_last [2];
  logic [IW-1:0] buf_id   [2];
  logic          wr_q, rd_q, pop;
  logic [1:0]    cnt_q;

  assign arb_rdy = (cnt_q != 2'd2);
  assign pop     = o_out_vld & i_out_rdy;

  always_ff @(posedge clk) begin
    if (fire) begin
      buf_dat[wr_q]  <= arb_dat;
      buf_last[wr_q] <= arb_last;
      buf_id[wr_q]   <= cur;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (fire) wr_q <= ~wr_q;
      if (pop)  rd_q <= ~rd_q;
      case ({fire, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign o_out_vld  = (cnt_q != 2'd0);
  assign o_out_dat  = buf_dat[rd_q];
  assign o_out_last = buf_last[rd_q];
  assign o_out_id   = buf_id[rd_q];
`else
  assign arb_rdy    = i_out_rdy;
  assign o_out_vld  = arb_vld;
  assign o_out_dat  = arb_dat;
  assign o_out_last = arb_last;
  assign o_out_id   = cur;
`endif

  for (genvar g = 0; g < N; g++) begin : g_req_chk
    a_req_hold: assert property (@(posedge clk) disable iff (!arst_n)
      (i_in_vld[g] && !o_in_rdy[g]) |=>
        (i_in_vld[g] && $stable(i_in_dat[g*W +: W]) && $stable(i_in_last[g])));
  end

  a_out_hold: assert property (@(posedge clk) disable iff (!arst_n)
    (o_out_vld && !i_out_rdy) |=>
      (o_out_vld && $stable(o_out_dat) && $stable(o_out_last) && $stable(o_out_id)));

endmodule
